// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with a 2-entry skid FIFO
// Decodes I/S/B/U/J/SHAMT immediates, buffers {imm, err}, counts illegal format selects.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [2:0]           IMMSrc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      imm_out,
  output logic                 imm_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [63:0]     dec_wide;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  logic [XLEN-1:0] mem_imm [2];
  logic            mem_err [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            rst_sync;
  logic            push;
  logic            pop;

  // The low opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Everything is built sign-extended to 64 bits, then cut down to XLEN.
  always_comb begin
    dec_wide = '0;
    dec_err  = 1'b0;
    case (IMMSrc)
      3'b000: dec_wide = {{52{instr[31]}}, instr[31:20]};
      3'b001: dec_wide = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: dec_wide = {{32{instr[31]}}, instr[31:12], 12'b0};
      3'b011: dec_wide = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      3'b100: dec_wide = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      3'b101: dec_wide = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      default: dec_err = 1'b1;
    endcase
  end

  assign dec_imm = dec_wide[XLEN-1:0];

  assign in_ready  = rst_sync && (count < 2'd2) && !flush;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign imm_out = out_valid ? mem_imm[rd_ptr] : '0;
  assign imm_err = out_valid ? mem_err[rd_ptr] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync   <= 1'b0;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      mem_imm[0] <= '0;
      mem_imm[1] <= '0;
      mem_err[0] <= 1'b0;
      mem_err[1] <= 1'b0;
    end else begin
      rst_sync <= 1'b1;
      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem_imm[wr_ptr] <= dec_imm;
          mem_err[wr_ptr] <= dec_err;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // push is already suppressed during flush, so a flush never touches the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (push && dec_err && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 side by side)
// Both instances share stimulus; a queue-based reference model predicts every output.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        out_ready;

  logic        in_ready32, out_valid32, imm_err32;
  logic [31:0] imm_out32;
  logic [7:0]  err_count32;
  logic        in_ready64, out_valid64, imm_err64;
  logic [63:0] imm_out64;
  logic [1:0]  err_count64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .ERR_CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .IMMSrc(imm_src), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_out(imm_out32), .imm_err(imm_err32), .err_count(err_count32)
  );

  imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .IMMSrc(imm_src), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_out(imm_out64), .imm_err(imm_err64), .err_count(err_count64)
  );

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic        err;
  } ent_t;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
    logic [31:0] e32;
    logic [63:0] e64;
  } vec_t;

  ent_t        q[$];
  logic [31:0] obs[$];
  int          cnt8, cnt2;
  bit          sync_ok;
  int          tests, fails;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint f, input int w);
    return (f >= (longint'(1) << (w - 1))) ? f - (longint'(1) << w) : f;
  endfunction

  // Reference decode from the field definitions, using signed integer arithmetic.
  function automatic logic [64:0] ref_dec(input logic [31:0] ins, input logic [2:0] src,
                                          input bit x64);
    longint v;
    case (src)
      3'd0: v = sx(longint'(ins[31:20]), 12);
      3'd1: v = sx(longint'({ins[31:25], ins[11:7]}), 12);
      3'd2: v = sx(longint'(ins[31:12]), 20) * 4096;
      3'd3: v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20) * 2;
      3'd4: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd5: v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12) * 2;
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, 64'(v)};
  endfunction

  task automatic check_all();
    ent_t e;
    bit   er;
    er = sync_ok && (q.size() < 2) && !flush;
    if (q.size() > 0) e = q[0];
    else begin
      e.i32 = '0; e.i64 = '0; e.err = 1'b0;
    end
    chk("in_ready32", 64'(in_ready32), 64'(er));
    chk("in_ready64", 64'(in_ready64), 64'(er));
    chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    chk("imm_out32", 64'(imm_out32), 64'(e.i32));
    chk("imm_out64", imm_out64, e.i64);
    chk("imm_err32", 64'(imm_err32), 64'(e.err));
    chk("imm_err64", 64'(imm_err64), 64'(e.err));
    chk("err_count32", 64'(err_count32), 64'(cnt8));
    chk("err_count64", 64'(err_count64), 64'(cnt2));
  endtask

  // One clock: check at negedge, advance the model at posedge, return #1 after it.
  task automatic cycle();
    bit          push, pop;
    logic [64:0] r32, r64;
    ent_t        e;
    @(negedge clk);
    check_all();
    push = in_valid && sync_ok && (q.size() < 2) && !flush;
    pop  = (q.size() > 0) && out_ready;
    if (pop) obs.push_back(imm_out32);
    r32  = ref_dec(instr, imm_src, 1'b0);
    r64  = ref_dec(instr, imm_src, 1'b1);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      cnt8 = 0; cnt2 = 0; sync_ok = 0;
    end else begin
      sync_ok = 1;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          e.i32 = r32[31:0]; e.i64 = r64[63:0]; e.err = r64[64];
          q.push_back(e);
        end
      end
      if (push && r64[64]) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3) cnt2++;
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [2:0] s, input logic [31:0] ins);
    in_valid = v; imm_src = s; instr = ins;
  endtask

  vec_t tbl[10];
  int   saved;

  initial begin
    tbl[0] = '{32'h7FF00013, 3'd0, 32'h000007FF, 64'h00000000000007FF};
    tbl[1] = '{32'hFFF00013, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    tbl[2] = '{32'h120001A3, 3'd1, 32'h00000123, 64'h0000000000000123};
    tbl[3] = '{32'hFE000FA3, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    tbl[4] = '{32'h00000463, 3'd5, 32'h00000008, 64'h0000000000000008};
    tbl[5] = '{32'h00000863, 3'd5, 32'h00000010, 64'h0000000000000010};
    tbl[6] = '{32'hABCDE037, 3'd2, 32'hABCDE000, 64'hFFFFFFFFABCDE000};
    tbl[7] = '{32'hFFFFF06F, 3'd3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE};
    tbl[8] = '{32'h81F00013, 3'd4, 32'h0000001F, 64'h000000000000001F};
    tbl[9] = '{32'h03F00013, 3'd4, 32'h0000001F, 64'h000000000000003F};

    tests = 0; fails = 0; cnt8 = 0; cnt2 = 0; sync_ok = 0;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 3'd0, 32'hFFFFFFFF);
    repeat (3) cycle();
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 32'h0);
    cycle();
    cycle();

    // Back-to-back decode vectors, each visible one edge after acceptance.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].src, tbl[i].ins);
      cycle();
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid32), 64'd1);
      chk($sformatf("tbl%0d_imm32", i), 64'(imm_out32), 64'(tbl[i].e32));
      chk($sformatf("tbl%0d_imm64", i), imm_out64, tbl[i].e64);
    end
    drive(1'b0, 3'd0, 32'h0);
    cycle();

    // Illegal selects and counter saturation on the narrow counter.
    drive(1'b1, 3'b110, 32'hFFFFFFFF);
    cycle();
    chk("ill110_err", 64'(imm_err32), 64'd1);
    chk("ill110_imm", 64'(imm_out32), 64'd0);
    drive(1'b1, 3'b111, 32'h12345678);
    cycle();
    chk("ill111_err", 64'(imm_err64), 64'd1);
    chk("ill111_imm", imm_out64, 64'd0);
    drive(1'b0, 3'd0, 32'h0);
    cycle();
    chk("err_cnt_2_w8", 64'(err_count32), 64'd2);
    chk("err_cnt_2_w2", 64'(err_count64), 64'd2);
    drive(1'b1, 3'b110, 32'h0);
    repeat (3) cycle();
    drive(1'b0, 3'd0, 32'h0);
    cycle();
    chk("err_cnt_5_w8", 64'(err_count32), 64'd5);
    chk("err_cnt_sat_w2", 64'(err_count64), 64'd3);

    // Backpressure: third input must wait, head stays put, order preserved.
    obs.delete();
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h00100013); cycle();
    drive(1'b1, 3'd0, 32'h00200013); cycle();
    drive(1'b1, 3'd0, 32'h00300013);
    chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
    repeat (3) cycle();
    chk("bp_head_stable", 64'(imm_out32), 64'd1);
    out_ready = 1'b1;
    cycle();
    cycle();
    drive(1'b0, 3'd0, 32'h0);
    repeat (3) cycle();
    chk("bp_pop_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      chk("bp_order0", 64'(obs[0]), 64'd1);
      chk("bp_order1", 64'(obs[1]), 64'd2);
      chk("bp_order2", 64'(obs[2]), 64'd3);
    end

    // Flush a full FIFO while offering an illegal input.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h00400013); cycle();
    drive(1'b1, 3'd0, 32'h00500013); cycle();
    saved = int'(err_count32);
    drive(1'b1, 3'b111, 32'h0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0);
    chk("flush_out_valid", 64'(out_valid32), 64'd0);
    chk("flush_err_cnt", 64'(err_count32), 64'(saved));
    cycle();
    out_ready = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      instr     = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset with two buffered entries.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h00600013);
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid32), 64'd0);
    chk("arst_imm_out", imm_out64, 64'd0);
    chk("arst_in_ready", 64'(in_ready32), 64'd0);
    chk("arst_err_count", 64'(err_count32), 64'd0);
    q.delete(); cnt8 = 0; cnt2 = 0; sync_ok = 0;
    drive(1'b0, 3'd0, 32'h0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    drive(1'b1, 3'd0, 32'hFFE00013);
    cycle();
    chk("post_rst_valid", 64'(out_valid32), 64'd1);
    chk("post_rst_imm", 64'(imm_out32), 64'hFFFFFFFE);
    drive(1'b0, 3'd0, 32'h0);
    out_ready = 1'b1;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
